// File: rtl/mem_responder.sv
// mem_responder: byte-addressed little-endian memory with fixed read latency,
// word/halfword/byte accesses, alignment checking and a one-cycle ready pulse.
module mem_responder #(
    parameter int DEPTH_BYTES = 256,
    parameter int READ_LAT    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_COMMIT, DONE} state_t;

    state_t      state, state_nx;
    logic [7:0]  mem [DEPTH_BYTES];
    logic [AW-1:0] a_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] wd_q;
    logic [2:0]  cnt;
    logic        bad;
    logic [3:0]  we;
    logic [7:0]  b [4];
    logic [31:0] rd_word;
    logic        unused_addr;

    // Address bits above the storage size are dropped (modulo DEPTH_BYTES).
    assign unused_addr = ^addr[31:AW];

    always_comb begin
        bad = (size_q == 2'b11) || (size_q == 2'b00 && a_q[1:0] != 2'b00) || (size_q == 2'b01 && a_q[0]);
        we = size_q == 2'b10 ? 4'b0001 : size_q == 2'b01 ? 4'b0011 : 4'b1111;
        for (int k = 0; k < 4; k++)
            b[k] = mem[a_q + AW'(k)];
        rd_word = bad ? 32'h0 :
                  size_q == 2'b10 ? {24'h0, b[0]} :
                  size_q == 2'b01 ? {16'h0, b[1], b[0]} : {b[3], b[2], b[1], b[0]};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (req) state_nx = wr ? WR_COMMIT : RD_WAIT;
            RD_WAIT:   if (cnt == 3'(READ_LAT - 1)) state_nx = DONE;
            WR_COMMIT: state_nx = DONE;
            default:   state_nx = IDLE;
        endcase
        ready = state == DONE;
        busy  = state != IDLE;
        err   = ready && bad;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rdata <= 32'h0;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= state == RD_WAIT ? cnt + 3'd1 : 3'd0;
            if (state == IDLE && req) begin
                a_q    <= addr[AW-1:0];
                wr_q   <= wr;
                size_q <= size;
                wd_q   <= wdata;
            end
            if (state == RD_WAIT && state_nx == DONE)
                rdata <= rd_word;
        end
    end

    // Storage is deliberately outside the reset domain; reset only blocks the commit.
    always_ff @(posedge clk) begin
        if (!reset && state == WR_COMMIT && wr_q && !bad)
            for (int k = 0; k < 4; k++)
                if (we[k])
                    mem[a_q + AW'(k)] <= wd_q[8*k +: 8];
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder (defaults DEPTH_BYTES=256, READ_LAT=3).
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        reset, req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    logic        ready, busy, err;
    int          n_checks = 0, n_fail = 0;
    int          lat, nready, first, second;
    logic        busy5;
    logic [31:0] rd;
    logic        er;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Waits for idle, issues one access, scrambles the inputs after acceptance,
    // and returns the number of edges from acceptance to ready.
    task automatic access(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req = 1'b1; wr = w; size = s; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; wr = ~w; size = ~s; addr = ~a; wdata = ~d;
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        lat = 0;
        while (!ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata;
        er = err;
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        @(negedge clk) reset = 1'b0;

        access(1'b1, 2'b00, 32'h10, 32'hDEADBEEF);
        check("wr_lat", lat, 32'd1);
        check("wr_err", {31'b0, er}, 32'd0);
        access(1'b0, 2'b00, 32'h10, 32'h0);
        check("rd_lat", lat, 32'd3);
        check("rd_word", rd, 32'hDEADBEEF);
        check("rd_err", {31'b0, er}, 32'd0);

        access(1'b1, 2'b10, 32'h11, 32'hFFFFFFAA);
        check("wrb_lat", lat, 32'd1);
        access(1'b0, 2'b00, 32'h10, 32'h0);
        check("rd_after_byte", rd, 32'hDEADAAEF);
        access(1'b0, 2'b10, 32'h13, 32'h0);
        check("rd_byte13", rd, 32'h000000DE);
        access(1'b0, 2'b01, 32'h12, 32'h0);
        check("rd_half12", rd, 32'h0000DEAD);

        access(1'b0, 2'b01, 32'h13, 32'h0);
        check("mis_half_lat", lat, 32'd3);
        check("mis_half_err", {31'b0, er}, 32'd1);
        check("mis_half_rdata", rd, 32'h0);
        @(posedge clk); #1;
        check("err_low_idle", {31'b0, err}, 32'd0);
        access(1'b1, 2'b00, 32'h12, 32'h11111111);
        check("mis_wr_lat", lat, 32'd1);
        check("mis_wr_err", {31'b0, er}, 32'd1);
        access(1'b0, 2'b00, 32'h10, 32'h0);
        check("mis_wr_nochange", rd, 32'hDEADAAEF);
        access(1'b0, 2'b11, 32'h10, 32'h0);
        check("rsv_err", {31'b0, er}, 32'd1);
        check("rsv_rdata", rd, 32'h0);

        access(1'b1, 2'b00, 32'h104, 32'hCAFEF00D);
        access(1'b0, 2'b00, 32'h04, 32'h0);
        check("wrap_rd", rd, 32'hCAFEF00D);
        access(1'b1, 2'b01, 32'h06, 32'h5555BEEF);
        access(1'b0, 2'b00, 32'h04, 32'h0);
        check("half_wr", rd, 32'hBEEFF00D);
        access(1'b1, 2'b00, 32'hFC, 32'h12345678);
        access(1'b0, 2'b10, 32'hFF, 32'h0);
        check("top_byte", rd, 32'h00000012);
        access(1'b0, 2'b00, 32'h1FC, 32'h0);
        check("top_word", rd, 32'h12345678);

        // req held high: ready after edges 4 and 9 counting acceptance as edge 1
        wait_idle();
        req = 1'b1; wr = 1'b0; size = 2'b00; addr = 32'h10;
        nready = 0; first = 0; second = 0; busy5 = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (i == 5) busy5 = busy;
            if (ready) begin
                nready++;
                if (first == 0) first = i; else second = i;
            end
        end
        req = 1'b0;
        check("b2b_first", first, 32'd4);
        check("b2b_second", second, 32'd9);
        check("b2b_count", nready, 32'd2);
        check("b2b_idle_gap", {31'b0, busy5}, 32'd0);
        check("b2b_rdata", rdata, 32'hDEADAAEF);

        wait_idle();
        req = 1'b1; wr = 1'b0; size = 2'b00; addr = 32'h04;
        nready = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (ready) nready++;
            req = (i == 1 || i == 2 || i == 4);
        end
        check("pulse_ignored", nready, 32'd1);
        check("pulse_idle", {31'b0, busy}, 32'd0);

        wait_idle();
        req = 1'b1; wr = 1'b0; size = 2'b00; addr = 32'h10;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("rrst_ready", {31'b0, ready}, 32'd0);
        check("rrst_busy", {31'b0, busy}, 32'd0);
        check("rrst_err", {31'b0, err}, 32'd0);
        check("rrst_rdata", rdata, 32'h0);
        @(negedge clk) reset = 1'b0;
        nready = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ready) nready++;
        end
        check("rrst_noready", nready, 32'd0);
        access(1'b0, 2'b00, 32'h04, 32'h0);
        check("rrst_mem_kept", rd, 32'hBEEFF00D);

        wait_idle();
        req = 1'b1; wr = 1'b1; size = 2'b00; addr = 32'h10; wdata = 32'h55555555;
        @(posedge clk); #1;
        req = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("wrst_busy", {31'b0, busy}, 32'd0);
        nready = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ready) nready++;
        end
        check("wrst_noready", nready, 32'd0);
        access(1'b0, 2'b00, 32'h10, 32'h0);
        check("wrst_aborted", rd, 32'hDEADAAEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
